dmem_dma: RTL and testbench
===========================

Name: dmem_dma

Overview:
Initiator-side engine for the single-port data memory interface: one write enable, a 6-bit word address, 32-bit write data, and combinational read data. It executes block fill and block copy commands against the data memory on behalf of the controller or testbench. It sits between a simple command port and the data memory port. It owns the memory port exclusively while busy and reports completion, an abort flag and an XOR checksum of the words written.

Parameters:
AW, 6, memory word-address width; memory depth is 2**AW words
DW, 32, data word width
LW, AW+1, length field width; allows 0..2**AW words

Ports:
clk  input  1  clock; all state changes on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; a command is accepted on a posedge with cmd_valid&&cmd_ready
cmd_op  input  1  0 = FILL, 1 = COPY
cmd_src  input  AW  COPY source start address (ignored for FILL)
cmd_dst  input  AW  destination start address
cmd_len  input  LW  word count
cmd_fill  input  DW  FILL data value
cmd_abort  input  1  abort request, honoured only while busy
busy  output  1  high in RD, WR, DONE
done  output  1  one-cycle pulse in DONE
aborted  output  1  valid with done; held until next accept
checksum  output  DW  XOR of all words written by the last command; held until next accept
mem_we  output  1  memory write enable
mem_a  output  AW  memory word address
mem_d  output  DW  memory write data
mem_q  input  DW  memory read data, combinational from mem_a

Behaviour:
- All outputs are decoded from registered state and registers only. There is no combinational path from cmd_* or mem_q to any output.
- Reset (rst_n=0 at posedge): state IDLE; cmd_ready=1; busy, done, aborted, mem_we = 0; mem_a, mem_d, checksum, and the internal pointers, count and buffer = 0.
- Reset mid-operation: the next posedge forces IDLE and drops mem_we. A partially completed copy or fill is not rolled back.
- States: IDLE, RD, WR, DONE.
- IDLE → on accept: latch src, dst, len, op and fill; clear checksum and aborted.
  - len=0 → DONE.
  - COPY → RD.
  - FILL → WR.
- RD (COPY only): mem_a=src_ptr, mem_we=0. On posedge, mem_q is captured into buf and the state moves to WR.
- WR: mem_we=1, mem_a=dst_ptr, mem_d = buf (COPY) or fill (FILL). On posedge:
  - checksum ^= mem_d;
  - dst_ptr++ and src_ptr++, each modulo 2**AW (63 wraps to 0);
  - count--.
  - If count reaches 0 → DONE. Otherwise COPY → RD, FILL → stays in WR.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready is 0 in DONE, so back-to-back commands have a one-cycle gap in IDLE.
- Throughput and latency, measured from the accept edge:
  - COPY of N words: 2N busy cycles in RD/WR, then DONE in cycle 2N+1.
  - FILL of N words: N cycles, then DONE in cycle N+1.
  - len=0: DONE in the first cycle after accept, with no memory access.
- Abort (cmd_abort=1 sampled at a posedge while busy):
  - in RD → DONE, no write for that word;
  - in WR → the current write completes, then DONE;
  - aborted=1 from that DONE until the next accept;
  - cmd_abort is ignored in IDLE and DONE.
- Overlapping COPY regions: strictly forward word-by-word semantics. Each read sees all earlier writes of the same command, so copying dst=src+1 replicates the word at src.
- The read-before-write ordering relies on the memory's combinational read port and write-on-posedge behaviour. The engine never reads and writes in the same cycle.
- cmd_len > 2**AW is out of range: it is clamped to 2**AW.

Test Plan:
- Reset, then FILL dst=5 len=3 fill=0xA5A5A5A5 → mem_we high for 3 cycles at addresses 5, 6, 7; done in cycle 4 after accept; checksum=0xA5A5A5A5; aborted=0.
- Preload mem[10..13]={1,2,3,4}, then COPY src=10 dst=40 len=4 → alternating RD/WR; mem[40..43]={1,2,3,4}; done in cycle 9; checksum=0x4.
- Wrap: COPY src=62 dst=0 len=4 with mem[62,63,0,1]={0x11,0x22,0x33,0x44} → forward overlap gives mem[0..3]={0x11,0x22,0x11,0x22}; source address sequence 62, 63, 0, 1.
- len=0 command → done pulse in the first cycle after accept; mem_we never asserted; checksum=0.
- Abort: FILL len=10 with cmd_abort pulsed during the 3rd WR cycle → exactly 3 writes; done with aborted=1. A subsequent COPY clears aborted at accept.
- Reset mid-COPY after 2 words → the next edge gives busy=0, mem_we=0, cmd_ready=1; the 2 completed words remain in memory and the destination beyond them is unchanged.

Source files
------------

// File: rtl/dmem_dma_if.sv
// dmem_dma command and data-memory bundle.
// slave = engine side, master = controller/memory side.
`timescale 1ns/1ps
interface dmem_dma_if #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int LW = AW + 1
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_fill;
  logic          cmd_abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [DW-1:0] checksum;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src,
    input  cmd_dst, cmd_len, cmd_fill,
    input  cmd_abort, mem_q,
    output cmd_ready, busy, done,
    output aborted, checksum,
    output mem_we, mem_a, mem_d
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src,
    output cmd_dst, cmd_len, cmd_fill,
    output cmd_abort, mem_q,
    input  cmd_ready, busy, done,
    input  aborted, checksum,
    input  mem_we, mem_a, mem_d
  );
endinterface

// File: rtl/dmem_dma.sv
// Block fill / block copy engine for the
// single-port data memory.
`timescale 1ns/1ps
module dmem_dma #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int LW = AW + 1
) (
  input logic      clk,
  input logic      rst_n,
  dmem_dma_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [LW-1:0] MAXLEN =
    LW'(64'd1 << AW);

  state_t        r_state;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [LW-1:0] r_cnt;
  logic          r_op;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_buf;
  logic [DW-1:0] r_cs;
  logic          r_ab;

  logic [LW-1:0] w_len;
  logic [DW-1:0] w_mem_d;
  logic [AW-1:0] w_mem_a;
  logic          w_last;

  assign w_len = (bus.cmd_len > MAXLEN) ?
                 MAXLEN : bus.cmd_len;

  assign w_mem_d = (r_state != S_WR) ? '0 :
                   (r_op ? r_buf : r_fill);

  assign w_mem_a = (r_state == S_RD) ? r_src :
                   (r_state == S_WR) ? r_dst :
                   '0;

  assign w_last = (r_cnt == LW'(1)) ||
                  bus.cmd_abort;

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mem_we    = (r_state == S_WR);
  assign bus.mem_a     = w_mem_a;
  assign bus.mem_d     = w_mem_d;
  assign bus.aborted   = r_ab;
  assign bus.checksum  = r_cs;

  // Command sequencer: one word per WR,
  // COPY interleaves a RD before each WR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_fill  <= '0;
      r_buf   <= '0;
      r_cs    <= '0;
      r_ab    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_src  <= bus.cmd_src;
            r_dst  <= bus.cmd_dst;
            r_cnt  <= w_len;
            r_op   <= bus.cmd_op;
            r_fill <= bus.cmd_fill;
            r_cs   <= '0;
            r_ab   <= 1'b0;
            if (w_len == '0)
              r_state <= S_DONE;
            else if (bus.cmd_op)
              r_state <= S_RD;
            else
              r_state <= S_WR;
          end
        end
        S_RD: begin
          if (bus.cmd_abort) begin
            r_ab    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_buf   <= bus.mem_q;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          r_cs  <= r_cs ^ w_mem_d;
          r_src <= r_src + AW'(1);
          r_dst <= r_dst + AW'(1);
          r_cnt <= r_cnt - LW'(1);
          if (w_last) begin
            r_ab    <= bus.cmd_abort;
            r_state <= S_DONE;
          end else if (r_op) begin
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dma.sv
// Scoreboard bench for dmem_dma: expected
// reads/writes queued, popped on DUT activity.
`timescale 1ns/1ps
module tb_dmem_dma;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int LW    = 7;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_dma_if #(.AW(AW), .DW(DW), .LW(LW)) bus();

  dmem_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;

  assign bus.mem_q = mem[bus.mem_a];

  always @(posedge clk) begin
    if (bus.mem_we)
      mem[bus.mem_a] <= bus.mem_d;
    else if (pre_we)
      mem[pre_a] <= pre_d;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    rq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Write / read monitor against the queues.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    ra;
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("wr_extra", 64'(wq.size()), 64'd1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 64'(bus.mem_a),
            64'(e[AW+DW-1:DW]));
        chk("wr_data", 64'(bus.mem_d),
            64'(e[DW-1:0]));
      end
    end else if (bus.busy === 1'b1 &&
                 bus.done === 1'b0) begin
      if (rq.size() == 0) begin
        chk("rd_extra", 64'(rq.size()), 64'd1);
      end else begin
        ra = rq.pop_front();
        chk("rd_addr", 64'(bus.mem_a), 64'(ra));
      end
    end
  end

  task automatic preload(input int a,
                         input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = AW'(a);
    pre_d  = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive(input bit op,
                       input int src, input int dst,
                       input int len,
                       input logic [DW-1:0] fill);
    @(negedge clk);
    chk("rdy_pre", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = AW'(src);
    bus.cmd_dst   = AW'(dst);
    bus.cmd_len   = LW'(len);
    bus.cmd_fill  = fill;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input bit op,
                         input int src, input int dst,
                         input int len,
                         input logic [DW-1:0] fill,
                         input int abort_at,
                         input int exp_cyc,
                         input bit exp_ab);
    int n;
    int cyc;
    int s;
    int d;
    logic [DW-1:0] v;
    logic [DW-1:0] cs;
    n  = (len > DEPTH) ? DEPTH : len;
    if (abort_at > 0 && abort_at < n) n = abort_at;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      s = (src + i) % DEPTH;
      d = (dst + i) % DEPTH;
      if (op) begin
        rq.push_back(AW'(s));
        v = ref_mem[s];
      end else begin
        v = fill;
      end
      ref_mem[d] = v;
      wq.push_back({AW'(d), v});
      cs ^= v;
    end
    drive(op, src, dst, len, fill);
    cyc = 1;
    chk("ab_clr", 64'(bus.aborted), 64'd0);
    chk("cs_clr", 64'(bus.checksum), 64'd0);
    while (bus.done !== 1'b1 && cyc < 200) begin
      bus.cmd_abort = (cyc == abort_at);
      @(negedge clk);
      cyc++;
    end
    bus.cmd_abort = 1'b0;
    chk("done_cyc", 64'(cyc), 64'(exp_cyc));
    chk("checksum", 64'(bus.checksum), 64'(cs));
    chk("aborted", 64'(bus.aborted), 64'(exp_ab));
    chk("wr_left", 64'(wq.size()), 64'd0);
    chk("rd_left", 64'(rq.size()), 64'd0);
    @(negedge clk);
    chk("done_1cy", 64'(bus.done), 64'd0);
    chk("rdy_post", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_fill  = '0;
    bus.cmd_abort = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ab", 64'(bus.aborted), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_a", 64'(bus.mem_a), 64'd0);
    chk("rst_d", 64'(bus.mem_d), 64'd0);
    chk("rst_cs", 64'(bus.checksum), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      preload(i, 32'hC0DE_0000 | DW'(i));

    run_cmd(1'b0, 0, 5, 3, 32'hA5A5_A5A5,
            0, 4, 1'b0);

    for (int i = 0; i < 4; i++)
      preload(10 + i, DW'(i + 1));
    run_cmd(1'b1, 10, 40, 4, '0, 0, 9, 1'b0);

    preload(62, 32'h11);
    preload(63, 32'h22);
    preload(0,  32'h33);
    preload(1,  32'h44);
    run_cmd(1'b1, 62, 0, 4, '0, 0, 9, 1'b0);
    chk("wrap0", 64'(ref_mem[2]), 64'h11);
    chk("wrap1", 64'(ref_mem[3]), 64'h22);

    run_cmd(1'b0, 0, 30, 0, 32'hFFFF_FFFF,
            0, 1, 1'b0);

    run_cmd(1'b0, 0, 20, 10, 32'h5A,
            3, 4, 1'b1);

    run_cmd(1'b1, 40, 30, 2, '0, 0, 5, 1'b0);

    for (int i = 0; i < 4; i++) begin
      preload(44 + i, 32'hA0 + DW'(i));
      preload(50 + i, 32'hB0 + DW'(i));
    end
    rq.push_back(AW'(44));
    rq.push_back(AW'(45));
    rq.push_back(AW'(46));
    wq.push_back({AW'(50), 32'hA0});
    wq.push_back({AW'(51), 32'hA1});
    ref_mem[50] = 32'hA0;
    ref_mem[51] = 32'hA1;
    drive(1'b1, 44, 50, 4, '0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_we", 64'(bus.mem_we), 64'd0);
    chk("mrst_rdy", 64'(bus.cmd_ready), 64'd1);
    chk("mrst_cs", 64'(bus.checksum), 64'd0);
    rst_n = 1'b1;
    chk("mrst_wq", 64'(wq.size()), 64'd0);
    chk("mrst_rq", 64'(rq.size()), 64'd0);

    run_cmd(1'b0, 0, 8, 100, 32'h77,
            0, 65, 1'b0);

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem%0d", i),
          64'(mem[i]), 64'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
